// File: rtl/hist_peak_finder.sv
// Scans every pixel's histogram once per frame and reports the peak bin per pixel.
// One bin read per cycle; results wait in OUT under pk_ready backpressure with RAM reads paused.
module hist_peak_finder #(
    parameter int BIN_NUM   = 16,
    parameter int BIN_W     = 4,
    parameter int PIXEL_NUM = 200,
    parameter int PIX_W     = 8,
    parameter int CNT_W     = 8,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [CNT_W-1:0]  thresh,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  rd_data,
    output logic              pk_valid,
    input  logic              pk_ready,
    output logic [PIX_W-1:0]  pk_pixel,
    output logic [BIN_W-1:0]  pk_bin,
    output logic [CNT_W-1:0]  pk_count,
    output logic              pk_found,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_CAPT,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(BIN_NUM - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM - 1);

    state_t              state_q, state_d;
    logic [PIX_W-1:0]    pixel_q, pixel_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    thresh_q, thresh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                init_q;
    logic                rd_vld_q;
    logic [BIN_W-1:0]    rd_bin_q;
    logic [CNT_W-1:0]    max_cnt_q, max_cnt_d;
    logic [BIN_W-1:0]    max_bin_q, max_bin_d;
    logic [PIX_W-1:0]    pk_pixel_q, pk_pixel_d;
    logic [BIN_W-1:0]    pk_bin_q, pk_bin_d;
    logic [CNT_W-1:0]    pk_count_q, pk_count_d;
    logic                pk_found_q, pk_found_d;
    logic [ADDR_W-1:0]   scan_addr;

    assign scan_addr = ADDR_W'(pixel_q) * ADDR_W'(BIN_NUM) + ADDR_W'(bin_q);

    assign rd_en    = (state_q == S_SCAN);
    assign rd_addr  = rd_en ? scan_addr : addr_q;
    assign pk_valid = (state_q == S_OUT);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign pk_pixel = pk_pixel_q;
    assign pk_bin   = pk_bin_q;
    assign pk_count = pk_count_q;
    assign pk_found = pk_found_q;

    // Bin 0 seeds the running max; later bins replace it only when strictly larger.
    always_comb begin
        max_cnt_d = max_cnt_q;
        max_bin_d = max_bin_q;
        if (rd_vld_q && ((rd_bin_q == '0) || (rd_data > max_cnt_q))) begin
            max_cnt_d = rd_data;
            max_bin_d = rd_bin_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        pixel_d    = pixel_q;
        bin_d      = bin_q;
        thresh_d   = thresh_q;
        addr_d     = addr_q;
        pk_pixel_d = pk_pixel_q;
        pk_bin_d   = pk_bin_q;
        pk_count_d = pk_count_q;
        pk_found_d = pk_found_q;
        case (state_q)
            S_IDLE: begin
                // init_q masks a start coinciding with reset release.
                if (start && init_q) begin
                    thresh_d = thresh;
                    pixel_d  = '0;
                    bin_d    = '0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                addr_d = scan_addr;
                if (bin_q == LAST_BIN) begin
                    bin_d   = '0;
                    state_d = S_CAPT;
                end else begin
                    bin_d = bin_q + BIN_W'(1);
                end
            end
            S_CAPT: begin
                pk_pixel_d = pixel_q;
                pk_bin_d   = max_bin_d;
                pk_count_d = max_cnt_d;
                pk_found_d = (max_cnt_d >= thresh_q);
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (pk_ready) begin
                    if (pixel_q < LAST_PIX) begin
                        pixel_d = pixel_q + PIX_W'(1);
                        bin_d   = '0;
                        state_d = S_SCAN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= S_IDLE;
            pixel_q    <= '0;
            bin_q      <= '0;
            thresh_q   <= '0;
            addr_q     <= '0;
            init_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_bin_q   <= '0;
            max_cnt_q  <= '0;
            max_bin_q  <= '0;
            pk_pixel_q <= '0;
            pk_bin_q   <= '0;
            pk_count_q <= '0;
            pk_found_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pixel_q    <= pixel_d;
            bin_q      <= bin_d;
            thresh_q   <= thresh_d;
            addr_q     <= addr_d;
            init_q     <= 1'b1;
            rd_vld_q   <= rd_en;
            rd_bin_q   <= bin_q;
            max_cnt_q  <= max_cnt_d;
            max_bin_q  <= max_bin_d;
            pk_pixel_q <= pk_pixel_d;
            pk_bin_q   <= pk_bin_d;
            pk_count_q <= pk_count_d;
            pk_found_q <= pk_found_d;
        end
    end

endmodule

// File: tb/tb_hist_peak_finder.sv
// Bench for hist_peak_finder: directed frames, RAM model, scoreboard queue checked by a monitor.
module tb_hist_peak_finder;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic [7:0]  thresh;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [7:0]  rd_data;
    logic        pk_valid;
    logic        pk_ready;
    logic [7:0]  pk_pixel;
    logic [3:0]  pk_bin;
    logic [7:0]  pk_count;
    logic        pk_found;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    hist_peak_finder dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .thresh   (thresh),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pk_valid (pk_valid),
        .pk_ready (pk_ready),
        .pk_pixel (pk_pixel),
        .pk_bin   (pk_bin),
        .pk_count (pk_count),
        .pk_found (pk_found),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [7:0] pix;
        logic [3:0] bin;
        logic [7:0] cnt;
        logic       found;
    } res_t;

    logic [7:0] mem [0:4095];
    res_t       exp_q [$];
    res_t       mon_got, mon_exp;
    int         tests = 0;
    int         fails = 0;
    int         nres  = 0;

    // Histogram RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    always @(negedge clk) begin
        if (!res && pk_valid && pk_ready) begin
            nres++;
            tests++;
            mon_got = {pk_pixel, pk_bin, pk_count, pk_found};
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL result_unexpected: got pixel %0d, none expected", pk_pixel);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    fails++;
                    $display("FAIL result: got pix=%0d bin=%0d cnt=%0d found=%0d, expected pix=%0d bin=%0d cnt=%0d found=%0d",
                             mon_got.pix, mon_got.bin, mon_got.cnt, mon_got.found,
                             mon_exp.pix, mon_exp.bin, mon_exp.cnt, mon_exp.found);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t mk(input int p, input int b, input int c, input bit f);
        res_t r;
        r.pix   = 8'(p);
        r.bin   = 4'(b);
        r.cnt   = 8'(c);
        r.found = f;
        return r;
    endfunction

    function automatic res_t ref_peak(input int p, input logic [7:0] th);
        logic [7:0] best;
        int         bb;
        best = mem[p*16];
        bb   = 0;
        for (int b = 1; b < 16; b++) begin
            if (mem[p*16+b] > best) begin
                best = mem[p*16+b];
                bb   = b;
            end
        end
        return mk(p, bb, int'(best), best >= th);
    endfunction

    // Leaves the caller #1 into cycle 1 (the cycle after the start edge).
    task automatic do_start(input logic [7:0] th);
        @(negedge clk);
        thresh = th;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        bit done_seen;
        bit hit;
        int dcnt;
        int post;

        res      = 1'b1;
        start    = 1'b0;
        thresh   = 8'd0;
        pk_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {rd_en, busy, done, pk_valid}, 0);
        check("reset_addr", rd_addr, 0);
        check("reset_pk", {pk_pixel, pk_bin, pk_count, pk_found}, 0);
        @(negedge clk);
        res = 1'b0;
        repeat (2) @(posedge clk);

        // Frame 1: directed pixels 0..3, rest zero, thresh 5, stall on pixel 3.
        mem[5] = 8'd9;
        for (int b = 0; b < 16; b++) mem[16+b] = 8'd2;
        mem[16] = 8'd7;
        mem[31] = 8'd7;
        mem[47] = 8'd255;
        for (int b = 0; b < 16; b++) mem[48+b] = 8'd1;
        mem[51] = 8'd4;
        exp_q.push_back(mk(0, 5, 9, 1));
        exp_q.push_back(mk(1, 0, 7, 1));
        exp_q.push_back(mk(2, 15, 255, 1));
        exp_q.push_back(mk(3, 3, 4, 0));
        for (int p = 4; p < 200; p++) exp_q.push_back(mk(p, 0, 0, 0));
        nres = 0;
        do_start(8'd5);
        done_seen = 1'b0;
        for (int cyc = 1; cyc <= 4000 && !done_seen; cyc++) begin
            if (cyc <= 16) check("f1_scan_addr", {rd_en, rd_addr}, {1'b1, 12'(cyc - 1)});
            if (cyc == 17) begin
                check("f1_capt_rd_en", rd_en, 0);
                check("f1_capt_addr_hold", rd_addr, 15);
                check("f1_capt_valid", pk_valid, 0);
            end
            if (cyc == 18) check("f1_first_valid", pk_valid, 1);
            if (cyc == 19) check("f1_valid_drop", pk_valid, 0);
            if (cyc == 30) begin
                start  = 1'b1;
                thresh = 8'd0;
            end
            if (cyc == 31) start = 1'b0;
            if (cyc == 71) pk_ready = 1'b0;
            if (cyc >= 72 && cyc <= 81) begin
                check("f1_stall_valid", pk_valid, 1);
                check("f1_stall_rd_en", rd_en, 0);
                check("f1_stall_fields", {pk_pixel, pk_bin, pk_count, pk_found}, {8'd3, 4'd3, 8'd4, 1'b0});
            end
            if (cyc == 82) pk_ready = 1'b1;
            if (cyc == 83) check("f1_resume_scan", {rd_en, rd_addr}, {1'b1, 12'd64});
            if (done) begin
                done_seen = 1'b1;
                check("f1_done_cycle", cyc, 3611);
                check("f1_busy_with_done", busy, 1);
            end
            @(posedge clk);
            #1;
        end
        check("f1_done_seen", done_seen, 1);
        check("f1_after_done", {done, busy}, 0);
        check("f1_results", nres, 200);
        check("f1_queue_empty", exp_q.size(), 0);

        // Frame 2: pseudo-random data, thresh 0, random ready, ignored start.
        for (int i = 0; i < 3200; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int b = 0; b < 16; b++) mem[160+b] = 8'd0;
        for (int b = 0; b < 16; b++) mem[176+b] = 8'd255;
        for (int p = 0; p < 200; p++) exp_q.push_back(ref_peak(p, 8'd0));
        check("f2_zero_pixel_model", exp_q[10], mk(10, 0, 0, 1));
        nres = 0;
        do_start(8'd0);
        dcnt = 0;
        post = 0;
        for (int cyc = 1; cyc <= 12000 && post < 20; cyc++) begin
            pk_ready = 1'($urandom_range(0, 1));
            if (cyc == 100) begin
                start  = 1'b1;
                thresh = 8'd77;
            end
            if (cyc == 101) start = 1'b0;
            if (done) begin
                dcnt++;
                if (dcnt == 1) check("f2_busy_with_done", busy, 1);
            end
            if (dcnt > 0) post++;
            @(posedge clk);
            #1;
        end
        check("f2_done_pulses", dcnt, 1);
        check("f2_busy_after", busy, 0);
        check("f2_results", nres, 200);
        check("f2_queue_empty", exp_q.size(), 0);

        // Frame 3: reset at pixel 57 bin 8, then rescan with thresh 240.
        pk_ready = 1'b1;
        for (int p = 0; p < 200; p++) exp_q.push_back(ref_peak(p, 8'd240));
        nres = 0;
        do_start(8'd240);
        hit = 1'b0;
        for (int cyc = 1; cyc <= 2000 && !hit; cyc++) begin
            if (rd_en && rd_addr == 12'd920) begin
                hit = 1'b1;
                check("f3_reset_point_cycle", cyc, 1035);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("f3_reset_point_seen", hit, 1);
        #1;
        res = 1'b1;
        #1;
        check("rst_mid_ctrl", {rd_en, busy, done, pk_valid}, 0);
        check("rst_mid_addr", rd_addr, 0);
        check("rst_mid_pk", {pk_pixel, pk_bin, pk_count, pk_found}, 0);
        check("rst_partial_results", nres, 57);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        res    = 1'b0;
        start  = 1'b1;
        thresh = 8'd240;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_at_reset_release", busy, 0);

        for (int p = 0; p < 200; p++) exp_q.push_back(ref_peak(p, 8'd240));
        nres = 0;
        do_start(8'd240);
        done_seen = 1'b0;
        for (int cyc = 1; cyc <= 4000 && !done_seen; cyc++) begin
            if (cyc == 1) check("f3_restart_addr", {rd_en, rd_addr}, {1'b1, 12'd0});
            if (done) begin
                done_seen = 1'b1;
                check("f3_done_cycle", cyc, 3601);
            end
            @(posedge clk);
            #1;
        end
        check("f3_done_seen", done_seen, 1);
        check("f3_results", nres, 200);
        check("f3_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
